st3_exe_mdu: RTL and testbench

Parametrised execute stage for the multi-cycle CPU. It sits between decode (`ID_EXE_bus_r`) and memory (`EXE_MEM_bus`). Single-cycle ALU operations complete in the same cycle, as they do today. An iterative multiply/divide unit (MDU) adds unsigned multiply-low, multiply-high, divide and remainder, holding `EXE_over` low until the result is ready. Datapath width and bus field widths are parameters.

---
 rtl/st3_exe_mdu.sv | 209 ++++++++++++++++++++
 tb/tb_st3_exe_mdu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/st3_exe_mdu.sv
// Execute stage: single-cycle ALU path plus an iterative radix-2 unsigned
// multiply/divide unit (MUL, MULHU, DIVU, REMU) that stalls EXE_over.

// One-hot controlled ALU. Control bits from MSB down: add, sub, slt, sltu,
// and, nor, or, xor, sll, srl, sra, lui. ALU_CTRL_W must be at least 12.
module alu #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 12
) (
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [XLEN-1:0]       alu_src1,
    input  logic [XLEN-1:0]       alu_src2,
    output logic [XLEN-1:0]       alu_result
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] op_res [ALU_CTRL_W];

    assign shamt = alu_src1[SH_W-1:0];

    // Every candidate result, indexed by its control bit.
    always_comb begin
        for (int k = 0; k < ALU_CTRL_W; k++) begin
            op_res[k] = '0;
        end
        op_res[ALU_CTRL_W-1]  = alu_src1 + alu_src2;
        op_res[ALU_CTRL_W-2]  = alu_src1 - alu_src2;
        op_res[ALU_CTRL_W-3]  = XLEN'($signed(alu_src1) < $signed(alu_src2));
        op_res[ALU_CTRL_W-4]  = XLEN'(alu_src1 < alu_src2);
        op_res[ALU_CTRL_W-5]  = alu_src1 & alu_src2;
        op_res[ALU_CTRL_W-6]  = ~(alu_src1 | alu_src2);
        op_res[ALU_CTRL_W-7]  = alu_src1 | alu_src2;
        op_res[ALU_CTRL_W-8]  = alu_src1 ^ alu_src2;
        op_res[ALU_CTRL_W-9]  = alu_src2 << shamt;
        op_res[ALU_CTRL_W-10] = alu_src2 >> shamt;
        op_res[ALU_CTRL_W-11] = $unsigned($signed(alu_src2) >>> shamt);
        op_res[ALU_CTRL_W-12] = {alu_src2[XLEN/2-1:0], {(XLEN/2){1'b0}}};
    end

    // One-hot select as an AND-OR mux.
    always_comb begin
        alu_result = '0;
        for (int k = 0; k < ALU_CTRL_W; k++) begin
            if (alu_control[k]) begin
                alu_result = alu_result | op_res[k];
            end
        end
    end
endmodule

module st3_exe_mdu #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 12,
    parameter int MEM_CTRL_W = 4,
    parameter int PC_W       = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          EXE_valid,
    input  logic [3+ALU_CTRL_W+3*XLEN+MEM_CTRL_W+6+PC_W-1:0] ID_EXE_bus_r,
    output logic                                          EXE_over,
    output logic                                          EXE_busy,
    output logic [MEM_CTRL_W+2*XLEN+6+PC_W-1:0]           EXE_MEM_bus,
    output logic [PC_W-1:0]                               EXE_pc
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [2:0] MD_MUL   = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_REMU  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    logic [2:0]            md_op;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [XLEN-1:0]       alu_operand1;
    logic [XLEN-1:0]       alu_operand2;
    logic [MEM_CTRL_W-1:0] mem_control;
    logic [XLEN-1:0]       store_data;
    logic                  rf_wen;
    logic [4:0]            rf_wdest;
    logic [PC_W-1:0]       pc;

    assign {md_op, alu_control, alu_operand1, alu_operand2, mem_control,
            store_data, rf_wen, rf_wdest, pc} = ID_EXE_bus_r;

    logic [XLEN-1:0] alu_result;

    alu #(.XLEN(XLEN), .ALU_CTRL_W(ALU_CTRL_W)) u_alu (
        .alu_control (alu_control),
        .alu_src1    (alu_operand1),
        .alu_src2    (alu_operand2),
        .alu_result  (alu_result)
    );

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   mcand_reg;    // multiplicand or divisor
    logic [2*XLEN-1:0] prod_reg;     // high half accumulates, low half holds multiplier
    logic [XLEN-1:0]   quot_reg;     // dividend shifts out as quotient shifts in
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   result_reg;

    logic              is_md;
    logic              accept;
    logic              last_iter;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_trial;
    logic              div_ok;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quot_step;
    logic [XLEN-1:0]   mdu_final;

    assign is_md     = (md_op >= MD_MUL) && (md_op <= MD_REMU);
    assign accept    = (state_reg == S_IDLE) && EXE_valid && is_md;
    assign last_iter = (count_reg == CNT_W'(XLEN - 1));

    // One radix-2 step of both shift-add multiply and restoring divide.
    // A zero divisor never yields a negative trial, so the quotient fills
    // with ones and the remainder ends up equal to the dividend.
    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
        prod_step = {mul_sum, prod_reg[XLEN-1:1]};
        rem_shift = {rem_reg, quot_reg[XLEN-1]};
        rem_trial = rem_shift - {1'b0, mcand_reg};
        div_ok    = ~rem_trial[XLEN];
        rem_step  = div_ok ? rem_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_step = {quot_reg[XLEN-2:0], div_ok};
        case (op_reg)
            MD_MUL:   mdu_final = prod_step[XLEN-1:0];
            MD_MULHU: mdu_final = prod_step[2*XLEN-1:XLEN];
            MD_DIVU:  mdu_final = quot_step;
            default:  mdu_final = rem_step;
        endcase
    end

    // State register and MDU datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            quot_reg   <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= md_op;
                mcand_reg <= alu_operand2;
                prod_reg  <= {{XLEN{1'b0}}, alu_operand1};
                quot_reg  <= alu_operand1;
                rem_reg   <= '0;
                count_reg <= '0;
            end else if (state_reg == S_BUSY && EXE_valid) begin
                prod_reg  <= prod_step;
                quot_reg  <= quot_step;
                rem_reg   <= rem_step;
                count_reg <= count_reg + 1'b1;
                if (last_iter) begin
                    result_reg <= mdu_final;
                end
            end
        end
    end

    // Next state and stage handshake; dropping EXE_valid while busy aborts.
    always_comb begin
        state_next = state_reg;
        EXE_over   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (EXE_valid) begin
                    if (is_md) begin
                        state_next = S_BUSY;
                    end else begin
                        EXE_over = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (!EXE_valid) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                EXE_over = EXE_valid;
                if (!EXE_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign EXE_busy    = (state_reg == S_BUSY);
    assign EXE_MEM_bus = {mem_control, store_data,
                          (state_reg == S_DONE) ? result_reg : alu_result,
                          rf_wen, rf_wdest, pc};
    assign EXE_pc      = pc;
endmodule

// File: tb/tb_st3_exe_mdu.sv
// Randomised bench for st3_exe_mdu with a cycle-level behavioural model.
module tb_st3_exe_mdu;
    localparam int XLEN       = 32;
    localparam int ALU_CTRL_W = 12;
    localparam int MEM_CTRL_W = 4;
    localparam int PC_W       = 32;
    localparam int IN_W  = 3 + ALU_CTRL_W + 3*XLEN + MEM_CTRL_W + 6 + PC_W;
    localparam int OUT_W = MEM_CTRL_W + 2*XLEN + 6 + PC_W;
    localparam int ADD = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             EXE_valid;
    logic [IN_W-1:0]  ID_EXE_bus_r;
    logic             EXE_over;
    logic             EXE_busy;
    logic [OUT_W-1:0] EXE_MEM_bus;
    logic [PC_W-1:0]  EXE_pc;

    // driven fields
    logic [2:0]  md_op;
    logic [11:0] alu_ctrl;
    logic [31:0] op1, op2, sdata, pc;
    logic [3:0]  memc;
    logic        rfw;
    logic [4:0]  rfd;
    int          alu_idx;

    // observed fields
    logic [3:0]  o_memc;
    logic [31:0] o_sdata, o_res, o_pc;
    logic        o_rfw;
    logic [4:0]  o_rfd;

    // model state
    int          cyc = 0;
    int          acc_cyc = -1000;
    int          end_busy = -1000;
    bit          md_live = 0;
    logic [31:0] md_exp = '0;
    bit          lit_valid = 0;
    logic [31:0] lit_exp = '0;
    bit          checking = 0;
    int          n_total = 0;
    int          n_pass = 0;

    assign ID_EXE_bus_r = {md_op, alu_ctrl, op1, op2, memc, sdata, rfw, rfd, pc};
    assign {o_memc, o_sdata, o_res, o_rfw, o_rfd, o_pc} = EXE_MEM_bus;

    st3_exe_mdu #(.XLEN(XLEN), .ALU_CTRL_W(ALU_CTRL_W), .MEM_CTRL_W(MEM_CTRL_W), .PC_W(PC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .EXE_valid    (EXE_valid),
        .ID_EXE_bus_r (ID_EXE_bus_r),
        .EXE_over     (EXE_over),
        .EXE_busy     (EXE_busy),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .EXE_pc       (EXE_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            3'd1:    return p[31:0];
            3'd2:    return p[63:32];
            3'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
        case (idx)
            11: return a + b;
            10: return a - b;
            9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  return (a < b) ? 32'd1 : 32'd0;
            7:  return a & b;
            6:  return ~(a | b);
            5:  return a | b;
            4:  return a ^ b;
            3:  return b << a[4:0];
            2:  return b >> a[4:0];
            1:  return $unsigned($signed(b) >>> a[4:0]);
            default: return {b[15:0], 16'h0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    endtask

    // Compare every cycle against the timing and arithmetic rules.
    always @(negedge clk) begin
        if (checking) begin
            bit md, exp_busy, exp_over;
            logic [31:0] exp_res;
            md       = (md_op >= 3'd1) && (md_op <= 3'd4);
            exp_busy = (cyc > acc_cyc) && (cyc <= end_busy);
            exp_over = EXE_valid && (!md || (md_live && cyc >= acc_cyc + XLEN + 1));
            exp_res  = md ? md_exp : ref_alu(alu_idx, op1, op2);
            chk("busy", 64'(EXE_busy), 64'(exp_busy));
            chk("over", 64'(EXE_over), 64'(exp_over));
            if (exp_over) chk("result", 64'(o_res), 64'(exp_res));
            if (exp_over && lit_valid) chk("literal", 64'(o_res), 64'(lit_exp));
            chk("passthru", 64'({o_memc, o_sdata, o_rfw, o_rfd}), 64'({memc, sdata, rfw, rfd}));
            chk("pc", 64'(o_pc), 64'(pc));
            chk("exe_pc", 64'(EXE_pc), 64'(pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side();
        memc  = 4'($urandom);
        sdata = $urandom;
        rfw   = 1'($urandom);
        rfd   = 5'($urandom);
        pc    = $urandom;
    endtask

    task automatic alu_lit(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        rand_side();
        md_op = 3'd0; alu_idx = idx; alu_ctrl = 12'(1) << idx;
        op1 = a; op2 = b; EXE_valid = 1'b1;
        lit_valid = 1; lit_exp = lit;
        $display("txn alu idx=%0d a=%h b=%h expect=%h", idx, a, b, lit);
        step();
        lit_valid = 0; EXE_valid = 1'b0;
    endtask

    task automatic run_alu(input int n);
        logic [2:0] ops [4];
        ops[0] = 3'd0; ops[1] = 3'd5; ops[2] = 3'd6; ops[3] = 3'd7;
        for (int i = 0; i < n; i++) begin
            rand_side();
            md_op = ops[$urandom_range(0, 3)];
            alu_idx = $urandom_range(0, 11); alu_ctrl = 12'(1) << alu_idx;
            op1 = $urandom; op2 = $urandom;
            EXE_valid = 1'($urandom); lit_valid = 0;
            $display("txn alu md_op=%0d idx=%0d valid=%0d a=%h b=%h", md_op, alu_idx, EXE_valid, op1, op2);
            step();
        end
    endtask

    // Present an MDU op; abort_after>0 drops EXE_valid that many cycles after accept.
    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int abort_after, input bit has_lit, input logic [31:0] lit);
        rand_side();
        md_op = op; alu_idx = $urandom_range(0, 11); alu_ctrl = 12'(1) << alu_idx;
        op1 = a; op2 = b; EXE_valid = 1'b1;
        md_exp = ref_md(op, a, b); lit_valid = has_lit; lit_exp = lit;
        acc_cyc = cyc; end_busy = cyc + XLEN; md_live = 1;
        $display("txn mdu op=%0d a=%h b=%h abort_after=%0d expect=%h", op, a, b, abort_after, md_exp);
        if (abort_after > 0) begin
            repeat (abort_after) step();
            EXE_valid = 1'b0; md_live = 0; end_busy = cyc;
        end else begin
            repeat (XLEN + 1) step();
            repeat ($urandom_range(0, 2)) step();
            EXE_valid = 1'b0; md_live = 0;
        end
        step();
        lit_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; EXE_valid = 1'b0; md_op = '0; alu_idx = ADD; alu_ctrl = 12'(1) << ADD;
        op1 = '0; op2 = '0; memc = '0; sdata = '0; rfw = 1'b0; rfd = '0; pc = '0;
        repeat (2) step();
        checking = 1;
        step();
        // reset and an MDU request together: reset wins, nothing starts
        md_op = 3'd1; op1 = 32'd9; op2 = 32'd9; EXE_valid = 1'b1;
        step();
        reset = 1'b0; EXE_valid = 1'b0;
        step();

        alu_lit(ADD, 32'd5, 32'd3, 32'd8);
        step();
        run_mdu(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0001);
        run_mdu(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE);
        run_mdu(3'd1, 32'd7, 32'd6, 0, 1, 32'd42);
        run_mdu(3'd3, 32'd100, 32'd7, 0, 1, 32'd14);
        run_mdu(3'd4, 32'd100, 32'd7, 0, 1, 32'd2);
        run_mdu(3'd3, 32'h8000_0000, 32'd1, 0, 1, 32'h8000_0000);
        run_mdu(3'd3, 32'h1234, 32'd0, 0, 1, 32'hFFFF_FFFF);
        run_mdu(3'd4, 32'h1234, 32'd0, 0, 1, 32'h1234);
        run_mdu(3'd1, 32'hDEAD_BEEF, 32'h55, 10, 0, 32'd0);
        run_mdu(3'd1, 32'd3, 32'd4, 0, 1, 32'd12);

        // reset five cycles into a multiply, then an ALU op
        rand_side();
        md_op = 3'd1; op1 = 32'h1234_5678; op2 = 32'd9; EXE_valid = 1'b1;
        md_exp = ref_md(3'd1, op1, op2); acc_cyc = cyc; end_busy = cyc + XLEN; md_live = 1;
        $display("txn mdu op=1 a=%h b=%h reset_after=5", op1, op2);
        repeat (5) step();
        reset = 1'b1; md_live = 0; end_busy = cyc;
        step();
        reset = 1'b0;
        alu_lit(ADD, 32'd5, 32'd3, 32'd8);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            int ab;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, XLEN) : 0;
            run_alu($urandom_range(0, 4));
            run_mdu(3'($urandom_range(1, 4)), a, b, ab, 0, 32'd0);
        end
        run_alu(6);
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
